// File: rtl/tcn_fifo_addr_encoder_mr.sv
// Multi-region TCN FIFO address encoder: maps logical activation-memory addresses
// onto NUM_REGIONS independent circular block buffers with one cycle of latency.
module tcn_fifo_addr_encoder_mr #(
    parameter int ADDR_W      = 16,
    parameter int NUM_REGIONS = 4,
    parameter int REG_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_active,
    input  logic              cfg_wr_en,
    input  logic [REG_W-1:0]  cfg_region,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_block_size,
    input  logic [ADDR_W-1:0] cfg_total_blocks,
    output logic              cfg_err,
    input  logic              rd_en,
    input  logic [REG_W-1:0]  rd_region,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [REG_W-1:0]  wr_region,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              update_en,
    input  logic [REG_W-1:0]  update_region,
    output logic              out_rd_en,
    output logic [ADDR_W-1:0] out_rd_addr,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_wr_addr,
    output logic              range_err
);

    logic [ADDR_W-1:0] base_q  [NUM_REGIONS];
    logic [ADDR_W-1:0] bs_q    [NUM_REGIONS];
    logic [ADDR_W:0]   size_q  [NUM_REGIONS];
    logic [ADDR_W-1:0] head_q  [NUM_REGIONS];
    logic              valid_q [NUM_REGIONS];
    logic [ADDR_W-1:0] base_d  [NUM_REGIONS];
    logic [ADDR_W-1:0] bs_d    [NUM_REGIONS];
    logic [ADDR_W:0]   size_d  [NUM_REGIONS];
    logic [ADDR_W-1:0] head_d  [NUM_REGIONS];
    logic              valid_d [NUM_REGIONS];

    logic              out_rd_en_q, out_rd_en_d, out_wr_en_q, out_wr_en_d;
    logic [ADDR_W-1:0] out_rd_addr_q, out_rd_addr_d, out_wr_addr_q, out_wr_addr_d;
    logic              range_err_q, range_err_d, cfg_err_q, cfg_err_d;

    logic [2*ADDR_W-1:0] cfg_prod_s;
    logic [2*ADDR_W-1:0] cfg_lim_s;
    logic                cfg_ok_s;
    logic                rd_ok_s, wr_ok_s;
    logic [ADDR_W-1:0]   rd_phys_s, wr_phys_s;

    function automatic logic region_in_range(input logic [REG_W-1:0] r);
        return (int'(r) < NUM_REGIONS);
    endfunction

    // One conditional subtract replaces the modulo: both operands are already below size.
    function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] x,
                                                   input logic [ADDR_W-1:0] y,
                                                   input logic [ADDR_W:0]   size);
        logic [ADDR_W+1:0] s;
        s = {2'b00, x} + {2'b00, y};
        s = (s >= {1'b0, size}) ? (s - {1'b0, size}) : s;
        return s[ADDR_W-1:0];
    endfunction

    function automatic logic addr_ok(input logic [REG_W-1:0]  r,
                                     input logic [ADDR_W-1:0] a,
                                     input logic              v,
                                     input logic [ADDR_W:0]   size);
        return region_in_range(r) && v && ({1'b0, a} < size);
    endfunction

    assign cfg_prod_s = {{ADDR_W{1'b0}}, cfg_block_size} * {{ADDR_W{1'b0}}, cfg_total_blocks};
    assign cfg_lim_s  = {{(ADDR_W-1){1'b0}}, 1'b1, {ADDR_W{1'b0}}};
    assign cfg_ok_s   = (cfg_prod_s != {(2*ADDR_W){1'b0}}) && (cfg_prod_s <= cfg_lim_s);

    assign rd_ok_s   = addr_ok(rd_region, rd_addr, valid_q[rd_region], size_q[rd_region]);
    assign wr_ok_s   = addr_ok(wr_region, wr_addr, valid_q[wr_region], size_q[wr_region]);
    assign rd_phys_s = base_q[rd_region] + wrap_add(rd_addr, head_q[rd_region], size_q[rd_region]);
    assign wr_phys_s = base_q[wr_region] + wrap_add(wr_addr, head_q[wr_region], size_q[wr_region]);

    // Per-region next state: an accepted config overrides a same-cycle head update.
    always_comb begin
        for (int r = 0; r < NUM_REGIONS; r++) begin
            base_d[r]  = base_q[r];
            bs_d[r]    = bs_q[r];
            size_d[r]  = size_q[r];
            head_d[r]  = head_q[r];
            valid_d[r] = valid_q[r];
            if (cfg_wr_en && cfg_ok_s && (cfg_region == REG_W'(r))) begin
                base_d[r]  = cfg_base;
                bs_d[r]    = cfg_block_size;
                size_d[r]  = cfg_prod_s[ADDR_W:0];
                head_d[r]  = {ADDR_W{1'b0}};
                valid_d[r] = 1'b1;
            end else if (update_en && valid_q[r] && (update_region == REG_W'(r))) begin
                head_d[r] = wrap_add(head_q[r], bs_q[r], size_q[r]);
            end else begin
                head_d[r] = head_q[r];
            end
        end
    end

    // Output next state: addresses hold unless their enable is accepted.
    always_comb begin
        out_rd_en_d   = 1'b0;
        out_wr_en_d   = 1'b0;
        out_rd_addr_d = out_rd_addr_q;
        out_wr_addr_d = out_wr_addr_q;
        range_err_d   = 1'b0;
        cfg_err_d     = cfg_wr_en && !cfg_ok_s;
        if (fifo_active) begin
            out_rd_en_d   = rd_en && rd_ok_s;
            out_wr_en_d   = wr_en && wr_ok_s;
            out_rd_addr_d = (rd_en && rd_ok_s) ? rd_phys_s : out_rd_addr_q;
            out_wr_addr_d = (wr_en && wr_ok_s) ? wr_phys_s : out_wr_addr_q;
            range_err_d   = (rd_en && !rd_ok_s) || (wr_en && !wr_ok_s);
        end else begin
            out_rd_en_d   = rd_en;
            out_wr_en_d   = wr_en;
            out_rd_addr_d = rd_en ? rd_addr : out_rd_addr_q;
            out_wr_addr_d = wr_en ? wr_addr : out_wr_addr_q;
        end
    end

    // Region configuration and head pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                base_q[r]  <= {ADDR_W{1'b0}};
                bs_q[r]    <= {ADDR_W{1'b0}};
                size_q[r]  <= {(ADDR_W+1){1'b0}};
                head_q[r]  <= {ADDR_W{1'b0}};
                valid_q[r] <= 1'b0;
            end
        end else begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                base_q[r]  <= base_d[r];
                bs_q[r]    <= bs_d[r];
                size_q[r]  <= size_d[r];
                head_q[r]  <= head_d[r];
                valid_q[r] <= valid_d[r];
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_rd_en_q   <= 1'b0;
            out_wr_en_q   <= 1'b0;
            out_rd_addr_q <= {ADDR_W{1'b0}};
            out_wr_addr_q <= {ADDR_W{1'b0}};
            range_err_q   <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            out_rd_en_q   <= out_rd_en_d;
            out_wr_en_q   <= out_wr_en_d;
            out_rd_addr_q <= out_rd_addr_d;
            out_wr_addr_q <= out_wr_addr_d;
            range_err_q   <= range_err_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign out_rd_en   = out_rd_en_q;
    assign out_wr_en   = out_wr_en_q;
    assign out_rd_addr = out_rd_addr_q;
    assign out_wr_addr = out_wr_addr_q;
    assign range_err   = range_err_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_tcn_fifo_addr_encoder_mr.sv
// Bench for tcn_fifo_addr_encoder_mr: directed steps plus random traffic against a
// modulo-arithmetic reference model of the circular regions.
module tb_tcn_fifo_addr_encoder_mr;

    localparam int AW = 16;
    localparam int NR = 4;
    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_active = 1'b0;
    logic          cfg_wr_en = 1'b0;
    logic [RW-1:0] cfg_region = '0;
    logic [AW-1:0] cfg_base = '0, cfg_block_size = '0, cfg_total_blocks = '0;
    logic          cfg_err;
    logic          rd_en = 1'b0, wr_en = 1'b0, update_en = 1'b0;
    logic [RW-1:0] rd_region = '0, wr_region = '0, update_region = '0;
    logic [AW-1:0] rd_addr = '0, wr_addr = '0;
    logic          out_rd_en, out_wr_en, range_err;
    logic [AW-1:0] out_rd_addr, out_wr_addr;

    tcn_fifo_addr_encoder_mr #(.ADDR_W(AW), .NUM_REGIONS(NR)) dut (
        .clk(clk), .reset(reset), .fifo_active(fifo_active),
        .cfg_wr_en(cfg_wr_en), .cfg_region(cfg_region), .cfg_base(cfg_base),
        .cfg_block_size(cfg_block_size), .cfg_total_blocks(cfg_total_blocks),
        .cfg_err(cfg_err),
        .rd_en(rd_en), .rd_region(rd_region), .rd_addr(rd_addr),
        .wr_en(wr_en), .wr_region(wr_region), .wr_addr(wr_addr),
        .update_en(update_en), .update_region(update_region),
        .out_rd_en(out_rd_en), .out_rd_addr(out_rd_addr),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
        .range_err(range_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    longint m_base[NR], m_bs[NR], m_size[NR], m_head[NR];
    bit     m_valid[NR];
    logic          e_rd_en, e_wr_en, e_range, e_cfg;
    logic [AW-1:0] e_rd_addr, e_wr_addr;

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_base[r] = 0; m_bs[r] = 0; m_size[r] = 0; m_head[r] = 0; m_valid[r] = 0;
        end
        e_rd_en = 0; e_wr_en = 0; e_range = 0; e_cfg = 0;
        e_rd_addr = '0; e_wr_addr = '0;
    endtask

    task automatic idle();
        cfg_wr_en = 0; rd_en = 0; wr_en = 0; update_en = 0;
    endtask

    function automatic bit in_region(input int r, input longint a);
        return m_valid[r] && (a < m_size[r]);
    endfunction

    function automatic logic [AW-1:0] phys(input int r, input longint a);
        longint p;
        p = (m_base[r] + ((a + m_head[r]) % m_size[r])) % 65536;
        return p[AW-1:0];
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".rd_en"},   {15'd0, out_rd_en}, {15'd0, e_rd_en});
        chk({tag, ".rd_addr"}, out_rd_addr, e_rd_addr);
        chk({tag, ".wr_en"},   {15'd0, out_wr_en}, {15'd0, e_wr_en});
        chk({tag, ".wr_addr"}, out_wr_addr, e_wr_addr);
        chk({tag, ".range"},   {15'd0, range_err}, {15'd0, e_range});
        chk({tag, ".cfg_err"}, {15'd0, cfg_err}, {15'd0, e_cfg});
    endtask

    // Predict from pre-edge state, advance the model, clock once and compare.
    task automatic cycle(input string tag);
        bit     rok, wok;
        longint prod;
        rok = in_region(int'(rd_region), longint'(rd_addr));
        wok = in_region(int'(wr_region), longint'(wr_addr));
        if (fifo_active) begin
            e_rd_en = rd_en && rok;
            e_wr_en = wr_en && wok;
            if (rd_en && rok) e_rd_addr = phys(int'(rd_region), longint'(rd_addr));
            if (wr_en && wok) e_wr_addr = phys(int'(wr_region), longint'(wr_addr));
            e_range = (rd_en && !rok) || (wr_en && !wok);
        end else begin
            e_rd_en = rd_en;
            e_wr_en = wr_en;
            if (rd_en) e_rd_addr = rd_addr;
            if (wr_en) e_wr_addr = wr_addr;
            e_range = 0;
        end
        prod  = longint'(cfg_block_size) * longint'(cfg_total_blocks);
        e_cfg = cfg_wr_en && (prod == 0 || prod > 65536);
        if (update_en && m_valid[update_region])
            m_head[update_region] = (m_head[update_region] + m_bs[update_region]) % m_size[update_region];
        if (cfg_wr_en && !e_cfg) begin
            m_base[cfg_region]  = cfg_base;
            m_bs[cfg_region]    = cfg_block_size;
            m_size[cfg_region]  = prod;
            m_head[cfg_region]  = 0;
            m_valid[cfg_region] = 1;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_cfg(input int r, input logic [AW-1:0] b, input logic [AW-1:0] bs,
                          input logic [AW-1:0] tb);
        idle();
        cfg_wr_en = 1; cfg_region = RW'(r); cfg_base = b;
        cfg_block_size = bs; cfg_total_blocks = tb;
        cycle("cfg");
        idle();
    endtask

    task automatic do_read(input int r, input logic [AW-1:0] a, input string tag);
        idle();
        rd_en = 1; rd_region = RW'(r); rd_addr = a;
        cycle(tag);
        idle();
    endtask

    task automatic do_update(input int r);
        idle();
        update_en = 1; update_region = RW'(r);
        cycle("upd");
        idle();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        reset = 0;
        fifo_active = 1;

        do_read(0, 16'd0, "unconfig_rd");
        chk("tp_unconfig_en", {15'd0, out_rd_en}, 16'd0);
        chk("tp_unconfig_err", {15'd0, range_err}, 16'd1);

        do_cfg(1, 16'h0100, 16'd4, 16'd3);
        do_read(1, 16'd5, "r1_a5");
        chk("tp_r1_a5", out_rd_addr, 16'h0105);
        do_update(1);
        do_read(1, 16'd5, "r1_a5_u1");
        chk("tp_r1_a5_u1", out_rd_addr, 16'h0109);
        do_update(1);
        do_read(1, 16'd5, "r1_a5_u2");
        chk("tp_r1_a5_wrap", out_rd_addr, 16'h0101);

        do_cfg(1, 16'h0100, 16'd4, 16'd3);
        do_cfg(2, 16'h0200, 16'd8, 16'd2);
        rd_en = 1; rd_region = 2'd1; rd_addr = 16'd2;
        wr_en = 1; wr_region = 2'd2; wr_addr = 16'd9;
        cycle("dual");
        idle();
        chk("tp_dual_rd", out_rd_addr, 16'h0102);
        chk("tp_dual_wr", out_wr_addr, 16'h0209);
        chk("tp_dual_en", {14'd0, out_rd_en, out_wr_en}, 16'd3);

        rd_en = 1; rd_region = 2'd1; rd_addr = 16'd0;
        update_en = 1; update_region = 2'd1;
        cycle("upd_rd");
        idle();
        chk("tp_upd_rd_old", out_rd_addr, 16'h0100);
        do_read(1, 16'd0, "upd_rd_new");
        chk("tp_upd_rd_new", out_rd_addr, 16'h0104);

        do_cfg(3, 16'h0000, 16'h0100, 16'h0101);
        chk("tp_cfg_reject", {15'd0, cfg_err}, 16'd1);
        do_read(3, 16'd0, "r3_invalid");
        chk("tp_r3_invalid", {15'd0, range_err}, 16'd1);
        do_cfg(0, 16'h0300, 16'h0100, 16'h0100);
        chk("tp_cfg_full_ok", {15'd0, cfg_err}, 16'd0);
        do_cfg(3, 16'hFFFE, 16'd4, 16'd1);
        do_read(3, 16'd3, "r3_wrap");
        chk("tp_addr_wrap", out_rd_addr, 16'h0001);
        do_read(3, 16'd4, "r3_edge");
        chk("tp_edge_hold", out_rd_addr, 16'h0001);
        chk("tp_edge_err", {15'd0, range_err}, 16'd1);

        fifo_active = 0;
        wr_en = 1; wr_region = 2'd0; wr_addr = 16'h1234;
        cycle("pass");
        idle();
        chk("tp_pass_addr", out_wr_addr, 16'h1234);
        chk("tp_pass_en", {15'd0, out_wr_en}, 16'd1);

        for (int i = 0; i < 500; i++) begin
            idle();
            fifo_active = ($urandom % 8) != 0;
            if ($urandom % 8 == 0) begin
                cfg_wr_en = 1;
                cfg_region = RW'($urandom);
                cfg_base = AW'($urandom);
                if ($urandom % 6 == 0) begin
                    cfg_block_size = AW'($urandom_range(255, 300));
                    cfg_total_blocks = AW'($urandom_range(255, 260));
                end else begin
                    cfg_block_size = AW'($urandom_range(0, 20));
                    cfg_total_blocks = AW'($urandom_range(0, 8));
                end
            end
            update_en = ($urandom % 4) == 0;
            update_region = RW'($urandom);
            rd_en = $urandom % 2;
            rd_region = RW'($urandom);
            rd_addr = AW'($urandom_range(0, 180));
            wr_en = $urandom % 2;
            wr_region = RW'($urandom);
            wr_addr = AW'($urandom_range(0, 180));
            cycle("rand");
        end

        fifo_active = 1;
        do_cfg(1, 16'h0100, 16'd4, 16'd3);
        rd_en = 1; rd_region = 2'd1; rd_addr = 16'd1;
        wr_en = 1; wr_region = 2'd1; wr_addr = 16'd2;
        cycle("burst");
        #1;
        reset = 1;
        #1;
        model_reset();
        check_outputs("mid_reset");
        @(posedge clk);
        #1;
        reset = 0;
        do_read(1, 16'd1, "post_reset");
        chk("tp_post_reset_err", {15'd0, range_err}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
